// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle of one req/gnt/rvalid memory port.
// The requester drives the master side and the responder drives the slave side.
interface mem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    // Requester side: issues the request, receives grant and response.
    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    // Responder side: accepts the request, returns grant and response.
    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Data wins by default. A starvation counter forces fetch through after
// STARVE_LIMIT back-to-back data grants. An owner FIFO records who issued each
// granted transaction, so in-order responses return to the right requester.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   instr_bus,
    mem_port_arbiter_if.slave   data_bus,
    mem_port_arbiter_if.master  mem_bus,
    output logic                protocol_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } sel_state_e;

    sel_state_e                 state_q;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_d;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [MAX_OUTSTANDING-1:0] owner_d;
    logic [STV_W-1:0]           starve_q;
    logic                       perr_q;

    logic fifo_full;
    logic fifo_empty;
    logic head_owner;
    logic sel_i;
    logic sel_d;
    logic instr_gnt;
    logic data_gnt;
    logic push;
    logic pop;
    logic stray_rvalid;
    logic route_i;
    logic route_d;

    // Fetch never writes, so these fields are intentionally left unused.
    logic unused_instr_fields;
    assign unused_instr_fields = ^{instr_bus.we, instr_bus.be, instr_bus.wdata};

    // The full check uses the registered count, so a pop in this cycle does not free a slot yet.
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_owner = owner_q[0];

    // Select a requester: a held request stays locked, otherwise arbitrate in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_full) begin
                        if (instr_bus.req && data_bus.req) begin
                            if (starve_q == STV_W'(STARVE_LIMIT)) sel_i = 1'b1;
                            else                                   sel_d = 1'b1;
                        end else if (instr_bus.req) begin
                            sel_i = 1'b1;
                        end else if (data_bus.req) begin
                            sel_d = 1'b1;
                        end
                    end
                end
                HOLD_I:  sel_i = 1'b1;
                HOLD_D:  sel_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Drive the memory request from the selected source; fetch reads whole words.
    always_comb begin
        mem_bus.req   = sel_i | sel_d;
        mem_bus.we    = 1'b0;
        mem_bus.be    = 4'h0;
        mem_bus.addr  = 32'h0;
        mem_bus.wdata = 32'h0;
        if (sel_d) begin
            mem_bus.we    = data_bus.we;
            mem_bus.be    = data_bus.be;
            mem_bus.addr  = data_bus.addr;
            mem_bus.wdata = data_bus.wdata;
        end else if (sel_i) begin
            mem_bus.be    = 4'hF;
            mem_bus.addr  = instr_bus.addr;
        end
    end

    assign instr_gnt     = sel_i & mem_bus.gnt;
    assign data_gnt      = sel_d & mem_bus.gnt;
    assign instr_bus.gnt = instr_gnt;
    assign data_bus.gnt  = data_gnt;

    assign push         = mem_bus.req & mem_bus.gnt;
    assign pop          = mem_bus.rvalid & ~fifo_empty;
    assign stray_rvalid = mem_bus.rvalid & fifo_empty;

    // Route each response to whoever issued the oldest outstanding transaction.
    assign route_i = pop & (head_owner == OWNER_INSTR);
    assign route_d = pop & (head_owner == OWNER_DATA);

    assign instr_bus.rvalid = route_i;
    assign instr_bus.err    = route_i & mem_bus.err;
    assign instr_bus.rdata  = route_i ? mem_bus.rdata : 32'h0;
    assign data_bus.rvalid  = route_d;
    assign data_bus.err     = route_d & mem_bus.err;
    assign data_bus.rdata   = route_d ? mem_bus.rdata : 32'h0;

    assign protocol_err_o = perr_q;

    // Owner FIFO next state: the head is bit 0; a pop shifts down and a push fills the first free slot.
    always_comb begin
        logic [CNT_W-1:0] wr_idx;
        owner_d = owner_q;
        if (pop) owner_d = owner_q >> 1;
        wr_idx = count_q - CNT_W'(pop);
        if (push) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (CNT_W'(i) == wr_idx) owner_d[i] = sel_d ? OWNER_DATA : OWNER_INSTR;
            end
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Selection FSM: lock the chosen source until memory grants it, so addr/we/be/wdata stay stable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            unique case (state_q)
                IDLE: begin
                    if (sel_i && !mem_bus.gnt)      state_q <= HOLD_I;
                    else if (sel_d && !mem_bus.gnt) state_q <= HOLD_D;
                end
                HOLD_I, HOLD_D: begin
                    if (mem_bus.gnt) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Owner FIFO storage and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the owner array is only a few flops and is reset along with the count, so the head is never X.
            owner_q <= '0;
            count_q <= '0;
        end else begin
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    // Starvation counter and the sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            if (instr_gnt || !instr_bus.req) begin
                starve_q <= '0;
            end else if (data_gnt && (starve_q != STV_W'(STARVE_LIMIT))) begin
                starve_q <= starve_q + 1'b1;
            end
            if (stray_rvalid) perr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A transaction-level model (an owner
// queue, a pending-request lock and a data-streak count) predicts every output
// each cycle. Hand-computed literals pin the key scenarios.
module tb_mem_port_arbiter;

    localparam int MAXO = 2;
    localparam int SL   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic protocol_err;

    always #5 clk = ~clk;

    mem_port_arbiter_if instr_if ();
    mem_port_arbiter_if data_if ();
    mem_port_arbiter_if mem_if ();

    mem_port_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (SL)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_bus      (instr_if),
        .data_bus       (data_if),
        .mem_bus        (mem_if),
        .protocol_err_o (protocol_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit owners[$];        // issuer of each outstanding transaction, oldest first (1 = data)
    int locked = -1;      // requester whose request is up but not yet accepted (-1 none, 0 instr, 1 data)
    int streak = 0;       // data grants in a row while fetch was waiting
    bit m_perr = 1'b0;

    always @(negedge clk) begin : compare
        int          choice;
        int          rsp_to;
        logic [69:0] exp_mem;
        logic [1:0]  exp_gnt;
        logic [33:0] exp_irsp;
        logic [33:0] exp_drsp;
        if (!rst_n) begin
            owners.delete();
            locked = -1;
            streak = 0;
            m_perr = 1'b0;
            check("rst_outputs",
                  128'({mem_if.req, mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata,
                        instr_if.gnt, data_if.gnt, instr_if.rvalid, instr_if.err, instr_if.rdata,
                        data_if.rvalid, data_if.err, data_if.rdata, protocol_err}),
                  128'(0));
        end else begin
            if (locked >= 0)                          choice = locked;
            else if (owners.size() >= MAXO)           choice = -1;
            else if (instr_if.req && data_if.req)     choice = (streak >= SL) ? 0 : 1;
            else if (instr_if.req)                    choice = 0;
            else if (data_if.req)                     choice = 1;
            else                                      choice = -1;

            case (choice)
                0:       exp_mem = {1'b1, 1'b0, 4'hF, instr_if.addr, 32'h0};
                1:       exp_mem = {1'b1, data_if.we, data_if.be, data_if.addr, data_if.wdata};
                default: exp_mem = '0;
            endcase
            exp_gnt = {(choice == 0) && mem_if.gnt, (choice == 1) && mem_if.gnt};

            rsp_to = -1;
            if (mem_if.rvalid && owners.size() > 0) rsp_to = owners[0] ? 1 : 0;
            exp_irsp = (rsp_to == 0) ? {1'b1, mem_if.err, mem_if.rdata} : 34'h0;
            exp_drsp = (rsp_to == 1) ? {1'b1, mem_if.err, mem_if.rdata} : 34'h0;

            check("mem_bus", 128'({mem_if.req, mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata}), 128'(exp_mem));
            check("grants", 128'({instr_if.gnt, data_if.gnt}), 128'(exp_gnt));
            check("instr_rsp", 128'({instr_if.rvalid, instr_if.err, instr_if.rdata}), 128'(exp_irsp));
            check("data_rsp", 128'({data_if.rvalid, data_if.err, data_if.rdata}), 128'(exp_drsp));
            check("protocol_err", 128'(protocol_err), 128'(m_perr));

            // Advance the model to what holds after the coming rising edge.
            if (mem_if.rvalid) begin
                if (owners.size() > 0) void'(owners.pop_front());
                else                   m_perr = 1'b1;
            end
            if (choice >= 0 && mem_if.gnt) owners.push_back(choice == 1);
            locked = (choice >= 0 && !mem_if.gnt) ? choice : -1;
            if (exp_gnt[1] || !instr_if.req) streak = 0;
            else if (exp_gnt[0])             streak = (streak + 1 > SL) ? SL : streak + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_if.req   = 1'b0; instr_if.we = 1'b0; instr_if.be = 4'h0;
        instr_if.addr  = 32'h0; instr_if.wdata = 32'h0;
        data_if.req    = 1'b0; data_if.we = 1'b0; data_if.be = 4'h0;
        data_if.addr   = 32'h0; data_if.wdata = 32'h0;
        mem_if.gnt     = 1'b0; mem_if.rvalid = 1'b0;
        mem_if.rdata   = 32'h0; mem_if.err = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] pat_d;
        logic [9:0] pat_i;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // T1: single store accepted immediately, response routed to data.
        data_if.req = 1'b1; data_if.we = 1'b1; data_if.addr = 32'h100;
        data_if.wdata = 32'hDEADBEEF; data_if.be = 4'b0011; mem_if.gnt = 1'b1;
        mid();
        check("t1_data_gnt", 128'(data_if.gnt), 128'(1));
        check("t1_instr_gnt", 128'(instr_if.gnt), 128'(0));
        check("t1_mem_addr", 128'(mem_if.addr), 128'(32'h100));
        check("t1_mem_wdata", 128'(mem_if.wdata), 128'(32'hDEADBEEF));
        check("t1_mem_be_we", 128'({mem_if.be, mem_if.we}), 128'({4'b0011, 1'b1}));
        tick();
        idle_inputs(); mem_if.rvalid = 1'b1; mem_if.rdata = 32'h0;
        mid();
        check("t1_data_rvalid", 128'(data_if.rvalid), 128'(1));
        check("t1_instr_rvalid", 128'(instr_if.rvalid), 128'(0));
        tick();
        idle_inputs();

        // T2: both request every cycle, grant pattern D,D,D,D,I repeats.
        for (int k = 0; k < 10; k++) begin
            instr_if.req = 1'b1; instr_if.addr = 32'h1000 + 32'(k * 4);
            data_if.req  = 1'b1; data_if.we = 1'b0; data_if.be = 4'hF;
            data_if.addr = 32'h2000 + 32'(k * 4);
            mem_if.gnt   = 1'b1; mem_if.rvalid = (k > 0); mem_if.rdata = 32'hA000 + 32'(k);
            mid();
            pat_d[9-k] = data_if.gnt;
            pat_i[9-k] = instr_if.gnt;
            tick();
        end
        check("t2_data_grant_pattern", 128'(pat_d), 128'(10'b1111011110));
        check("t2_instr_grant_pattern", 128'(pat_i), 128'(10'b0000100001));
        idle_inputs(); mem_if.rvalid = 1'b1; mem_if.rdata = 32'hA00A;
        tick();
        idle_inputs();

        // T3: fetch held three cycles without grant; data joins in cycle 2.
        instr_if.req = 1'b1; instr_if.addr = 32'h200;
        mid(); check("t3_addr_c0", 128'(mem_if.addr), 128'(32'h200));
        tick();
        mid(); check("t3_addr_c1", 128'(mem_if.addr), 128'(32'h200));
        tick();
        data_if.req = 1'b1; data_if.we = 1'b1; data_if.addr = 32'h300;
        data_if.wdata = 32'h55; data_if.be = 4'hF;
        mid();
        check("t3_addr_c2", 128'(mem_if.addr), 128'(32'h200));
        check("t3_we_c2", 128'(mem_if.we), 128'(0));
        tick();
        mem_if.gnt = 1'b1;
        mid(); check("t3_instr_first", 128'({instr_if.gnt, data_if.gnt}), 128'(2'b10));
        tick();
        instr_if.req = 1'b0;
        mid();
        check("t3_data_second", 128'({instr_if.gnt, data_if.gnt}), 128'(2'b01));
        check("t3_addr_c4", 128'(mem_if.addr), 128'(32'h300));
        tick();
        idle_inputs(); mem_if.rvalid = 1'b1; mem_if.rdata = 32'hA1;
        tick();
        mem_if.rdata = 32'hA2;
        tick();
        idle_inputs();

        // T4: fill the FIFO, block a third request, route responses in order.
        instr_if.req = 1'b1; instr_if.addr = 32'h400; mem_if.gnt = 1'b1;
        tick();
        instr_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h500; data_if.be = 4'hF;
        tick();
        data_if.req = 1'b0; instr_if.req = 1'b1; instr_if.addr = 32'h404;
        mid(); check("t4_blocked", 128'({mem_if.req, instr_if.gnt}), 128'(2'b00));
        tick();
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'h11;
        mid();
        check("t4_instr_rsp", 128'({instr_if.rvalid, instr_if.rdata}), 128'({1'b1, 32'h11}));
        check("t4_still_blocked", 128'(instr_if.gnt), 128'(0));
        tick();
        mem_if.rdata = 32'h22;
        mid();
        check("t4_data_rsp", 128'({data_if.rvalid, data_if.rdata}), 128'({1'b1, 32'h22}));
        check("t4_instr_rdata_zero", 128'(instr_if.rdata), 128'(0));
        check("t4_unblocked", 128'(instr_if.gnt), 128'(1));
        tick();
        instr_if.req = 1'b0; mem_if.gnt = 1'b0; mem_if.rdata = 32'h33;
        tick();
        idle_inputs();

        // T5: response with nothing outstanding.
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'hBAD;
        mid(); check("t5_no_rvalid", 128'({instr_if.rvalid, data_if.rvalid}), 128'(2'b00));
        tick();
        idle_inputs();
        mid(); check("t5_perr_set", 128'(protocol_err), 128'(1));
        repeat (2) tick();
        mid(); check("t5_perr_sticky", 128'(protocol_err), 128'(1));
        tick();

        // T6: reset with two transactions outstanding.
        instr_if.req = 1'b1; instr_if.addr = 32'h700; mem_if.gnt = 1'b1;
        tick();
        instr_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h704; data_if.be = 4'hF;
        tick();
        rst_n = 1'b0;
        instr_if.req = 1'b1; data_if.req = 1'b1; mem_if.gnt = 1'b1;
        mem_if.rvalid = 1'b1; mem_if.rdata = 32'h99;
        mid();
        check("t6_rst_mem_req", 128'(mem_if.req), 128'(0));
        check("t6_rst_gnt", 128'({instr_if.gnt, data_if.gnt}), 128'(2'b00));
        check("t6_rst_rsp", 128'({instr_if.rvalid, data_if.rvalid}), 128'(2'b00));
        check("t6_rst_perr", 128'(protocol_err), 128'(0));
        tick();
        rst_n = 1'b1;
        idle_inputs(); mem_if.rvalid = 1'b1; mem_if.rdata = 32'h77;
        mid(); check("t6_late_rsp_dropped", 128'({instr_if.rvalid, data_if.rvalid}), 128'(2'b00));
        tick();
        idle_inputs();
        data_if.req = 1'b1; data_if.addr = 32'h600; data_if.be = 4'hF; mem_if.gnt = 1'b1;
        mid();
        check("t6_new_gnt", 128'(data_if.gnt), 128'(1));
        check("t6_perr_after", 128'(protocol_err), 128'(1));
        tick();
        idle_inputs(); mem_if.rvalid = 1'b1; mem_if.rdata = 32'h66;
        mid(); check("t6_new_rsp", 128'({data_if.rvalid, data_if.rdata}), 128'({1'b1, 32'h66}));
        tick();
        idle_inputs();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
